// File: rtl/uart_avalon_pkg.sv
// Shared definitions for the UART receive Avalon-MM slave.
// Holds the bus and receiver state encodings, the register addresses and
// the bit positions of the DATA and CONTROL words.
package uart_avalon_pkg;

  // Bus handshake states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_e;

  // Serial receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Register map
  localparam logic ADDR_DATA    = 1'b0;
  localparam logic ADDR_CONTROL = 1'b1;

  // CONTROL / DATA word fields
  localparam int unsigned RE_BIT     = 0;
  localparam int unsigned RI_BIT     = 8;
  localparam int unsigned OV_BIT     = 10;
  localparam int unsigned RVALID_BIT = 15;
  localparam int unsigned RAVAIL_LSB = 16;
  localparam int unsigned RAVAIL_W   = 16;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/uart_avalon_slave_rx.sv
// 8N1 serial receiver.
// Ports:
//   clock_in, reset_in   - clock and synchronous active-high reset
//   rx_in                - asynchronous serial line, idle high
//   byte_out[7:0]        - last correctly framed byte
//   byte_valid           - one-cycle pulse when byte_out is updated
module uart_rx
  import uart_avalon_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              rx_in,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_M1 = BAUD_W'(CLKS_PER_BIT - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              prev_q, prev_d;
  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;

  // Next-state: synchronizer, start detection, half-bit aligned sampling
  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          baud_d  = '0;
        end
      end
      RX_START: begin
        if (baud_q == HALF_M1) begin
          baud_d = '0;
          bit_d  = '0;
          // A line that is high again at half-bit was only a glitch
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      RX_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {sync2_q, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      RX_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          state_d = RX_IDLE;
          // Framing errors simply drop the byte
          if (sync2_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // State registers; the synchronizer resets to the idle line level
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;

endmodule

// File: rtl/uart_avalon_slave.sv
// Avalon-MM slave exposing a UART receive FIFO through DATA and CONTROL.
// Ports:
//   clock_in, reset_in          - clock and synchronous active-high reset
//   rx_in                       - serial input, idle high
//   chipselect_in, address_in   - Avalon select, 0 = DATA, 1 = CONTROL
//   read_n_in, write_n_in       - active-low strobes
//   writedata_in[31:0]          - write data
//   readdata_out[31:0]          - read data, valid while waitrequest_out = 0
//   waitrequest_out             - 0 only in the single completion cycle
//   irq_out                     - registered RE && FIFO not empty
module uart_avalon_slave
  import uart_avalon_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 64
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              rx_in,
  input  logic              chipselect_in,
  input  logic              address_in,
  input  logic              read_n_in,
  input  logic              write_n_in,
  input  logic [WORD_W-1:0] writedata_in,
  output logic [WORD_W-1:0] readdata_out,
  output logic              waitrequest_out,
  output logic              irq_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid;

  logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  bus_state_e        state_q, state_d;
  logic              addr_q, addr_d;
  logic              is_rd_q, is_rd_d;
  logic              wr_re_q, wr_re_d;
  logic              wr_clr_q, wr_clr_d;
  logic              pop_pend_q, pop_pend_d;
  logic              re_q, re_d;
  logic              ov_q, ov_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              wait_q, wait_d;
  logic              irq_q, irq_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              overflow;
  logic              pop;
  logic [WORD_W-1:0] word;
  logic              wdata_unused;

  // Only RE and the OV-clear bit of a CONTROL write carry meaning
  assign wdata_unused = ^{writedata_in[WORD_W-1:OV_BIT+1], writedata_in[OV_BIT-1:RE_BIT+1]};

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .rx_in     (rx_in),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid)
  );

  // FIFO status and push/pop qualification
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    push       = rx_valid && !fifo_full;
    overflow   = rx_valid && fifo_full;
    pop        = (state_q == ST_ACK) && pop_pend_q;
  end

  // Read word as seen from the latched address
  always_comb begin
    word = '0;
    if (addr_q == ADDR_DATA) begin
      if (!fifo_empty) begin
        word[BYTE_W-1:0]              = mem_q[rd_ptr_q];
        word[RVALID_BIT]              = 1'b1;
        word[RAVAIL_LSB +: RAVAIL_W]  = RAVAIL_W'(count_q - CNT_W'(1));
      end
    end else begin
      word[RE_BIT]                    = re_q;
      word[RI_BIT]                    = !fifo_empty;
      word[OV_BIT]                    = ov_q;
      word[RAVAIL_LSB +: RAVAIL_W]    = RAVAIL_W'(count_q);
    end
  end

  // Next-state: FIFO pointers, bus handshake and control register
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    addr_d     = addr_q;
    is_rd_d    = is_rd_q;
    wr_re_d    = wr_re_q;
    wr_clr_d   = wr_clr_q;
    pop_pend_d = pop_pend_q;
    re_d       = re_q;
    ov_d       = ov_q;
    rdata_d    = rdata_q;
    wait_d     = 1'b1;
    irq_d      = re_q && !fifo_empty;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (chipselect_in && (!read_n_in || !write_n_in)) begin
          addr_d   = address_in;
          is_rd_d  = !read_n_in;
          wr_re_d  = writedata_in[RE_BIT];
          wr_clr_d = writedata_in[OV_BIT];
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        rdata_d    = word;
        // Decide the pop now so the returned head and the pop agree
        pop_pend_d = is_rd_q && (addr_q == ADDR_DATA) && !fifo_empty;
        wait_d     = 1'b0;
        state_d    = ST_ACK;
      end
      ST_ACK: begin
        if (!is_rd_q && (addr_q == ADDR_CONTROL)) begin
          re_d = wr_re_q;
          if (wr_clr_q) begin
            ov_d = 1'b0;
          end
        end
        pop_pend_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An overflow in the same cycle as a clear keeps OV set
    if (overflow) begin
      ov_d = 1'b1;
    end
  end

  // FIFO storage, not reset; pointers decide what is valid
  always_ff @(posedge clock_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_byte;
    end
  end

  // State registers
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      addr_q     <= ADDR_DATA;
      is_rd_q    <= 1'b0;
      wr_re_q    <= 1'b0;
      wr_clr_q   <= 1'b0;
      pop_pend_q <= 1'b0;
      re_q       <= 1'b0;
      ov_q       <= 1'b0;
      rdata_q    <= '0;
      wait_q     <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      is_rd_q    <= is_rd_d;
      wr_re_q    <= wr_re_d;
      wr_clr_q   <= wr_clr_d;
      pop_pend_q <= pop_pend_d;
      re_q       <= re_d;
      ov_q       <= ov_d;
      rdata_q    <= rdata_d;
      wait_q     <= wait_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata_out    = rdata_q;
  assign waitrequest_out = wait_q;
  assign irq_out         = irq_q;

endmodule

// File: tb/tb_uart_avalon_slave.sv
// Directed and randomized bench for uart_avalon_slave with a queue-based model.
module tb_uart_avalon_slave;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        cs;
  logic        addr;
  logic        rd_n;
  logic        wr_n;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wreq;
  logic        irq;

  always #5 clk = ~clk;

  uart_avalon_slave #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock_in       (clk),
    .reset_in       (rst),
    .rx_in          (rx),
    .chipselect_in  (cs),
    .address_in     (addr),
    .read_n_in      (rd_n),
    .write_n_in     (wr_n),
    .writedata_in   (wdata),
    .readdata_out   (rdata),
    .waitrequest_out(wreq),
    .irq_out        (irq)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: received bytes, RE and sticky OV
  logic [7:0] mq[$];
  logic       m_re;
  logic       m_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_re = 1'b0;
    m_ov = 1'b0;
  endfunction

  function automatic void model_push(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (mq.size() == DEPTH) m_ov = 1'b1;
      else mq.push_back(b);
    end
  endfunction

  function automatic logic [31:0] model_data_read();
    logic [31:0] w;
    if (mq.size() == 0) return 32'h0;
    w = {16'(mq.size() - 1), 8'h80, 8'h00};
    w[7:0] = mq.pop_front();
    return w;
  endfunction

  function automatic logic [31:0] model_ctrl();
    return {16'(mq.size()), 5'b0, m_ov, 1'b0, (mq.size() != 0), 7'b0, m_re};
  endfunction

  function automatic void model_ctrl_write(input logic [31:0] wd);
    m_re = wd[0];
    if (wd[10]) m_ov = 1'b0;
  endfunction

  // One Avalon access; lat = cycles from strobe to waitrequest low (0 = timeout)
  task automatic bus(input logic is_rd, input logic a, input logic [31:0] wd,
                     output logic [31:0] rv, output int lat);
    @(negedge clk);
    cs = 1'b1; addr = a; rd_n = !is_rd; wr_n = is_rd; wdata = wd;
    lat = 0;
    rv  = 32'hDEAD_BEEF;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!wreq) begin
        lat = i;
        rv  = rdata;
        break;
      end
    end
    cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    check("bus_ack_seen", 32'(lat != 0), 32'd1);
  endtask

  task automatic data_read(input string tag);
    logic [31:0] rv;
    logic [31:0] exp;
    int          lat;
    bus(1'b1, 1'b0, 32'h0, rv, lat);
    exp = model_data_read();
    check(tag, rv, exp);
  endtask

  task automatic ctrl_read(input string tag);
    logic [31:0] rv;
    int          lat;
    bus(1'b1, 1'b1, 32'h0, rv, lat);
    check(tag, rv, model_ctrl());
  endtask

  task automatic ctrl_write(input logic [31:0] wd);
    logic [31:0] rv;
    int          lat;
    bus(1'b0, 1'b1, wd, rv, lat);
    model_ctrl_write(wd);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk); rx = 1'b0; repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rx = b[i]; repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk); rx = stop; repeat (CPB - 1) @(negedge clk);
    @(negedge clk); rx = 1'b1; repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    @(negedge clk); rx = 1'b0; repeat (len - 1) @(negedge clk);
    @(negedge clk); rx = 1'b1; repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    logic [31:0] exp;
    logic [31:0] caps[$];
    logic [7:0]  b;
    logic        stop;
    int          lat;
    int          cyc;
    int          acks;

    rx = 1'b1; cs = 1'b0; addr = 1'b0; rd_n = 1'b1; wr_n = 1'b1; wdata = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_waitrequest", 32'(wreq), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_readdata", rdata, 32'h0);
    rst = 1'b0;

    // 1: enable interrupts, two bytes, irq timing
    bus(1'b0, 1'b1, 32'h1, rv, lat);
    model_ctrl_write(32'h1);
    check("t1_ctrl_wr_latency", 32'(lat), 32'd2);
    check("t1_irq_idle", 32'(irq), 32'd0);
    cyc = 0;
    fork
      send_frame(8'h12, 1'b1);
      begin
        while (!irq && cyc < 300) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    model_push(8'h12, 1'b1);
    check("t1_irq_rise_window", 32'(cyc >= 78 && cyc <= 84), 32'd1);
    send_frame(8'h34, 1'b1);
    model_push(8'h34, 1'b1);
    bus(1'b1, 1'b0, 32'h0, rv, lat);
    void'(model_data_read());
    check("t1_read0", rv, 32'h0001_8012);
    check("t1_read_latency", 32'(lat), 32'd2);
    bus(1'b1, 1'b0, 32'h0, rv, lat);
    void'(model_data_read());
    check("t1_read1", rv, 32'h0000_8034);
    @(negedge clk);
    check("t1_irq_after_pop_1", 32'(irq), 32'd1);
    @(negedge clk);
    check("t1_irq_after_pop_2", 32'(irq), 32'd0);

    // 2: empty read
    data_read("t2_empty_read");
    ctrl_read("t2_ctrl_after_empty");
    check("t2_ctrl_literal", model_ctrl(), 32'h0000_0001);

    // 3: overflow
    ctrl_write(32'h0);
    for (int i = 0; i < 5; i++) begin
      send_frame(8'hA0 + 8'(i), 1'b1);
      model_push(8'hA0 + 8'(i), 1'b1);
    end
    bus(1'b1, 1'b1, 32'h0, rv, lat);
    check("t3_ctrl_full_ov", rv, 32'h0004_0500);
    bus(1'b1, 1'b0, 32'h0, rv, lat);
    void'(model_data_read());
    check("t3_head_after_ov", rv, 32'h0003_80A0);
    ctrl_write(32'h400);
    ctrl_read("t3_ov_cleared");
    for (int i = 0; i < 3; i++) data_read("t3_drain");

    // 4: framing error and glitch
    send_frame(8'h55, 1'b0);
    glitch(3);
    ctrl_read("t4_no_push");

    // 5: held read strobe
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_push(b, 1'b1);
    end
    @(negedge clk);
    cs = 1'b1; addr = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (!wreq) begin
        acks++;
        caps.push_back(rdata);
      end
    end
    cs = 1'b0; rd_n = 1'b1;
    check("t5_ack_count", 32'(acks), 32'd3);
    for (int k = 0; k < 3; k++) begin
      exp = model_data_read();
      rv  = (k < caps.size()) ? caps[k] : 32'hDEAD_BEEF;
      check("t5_held_read", rv, exp);
    end

    // 6: reset in WAIT with a frame in flight and a byte queued
    ctrl_write(32'h1);
    b = 8'($urandom);
    send_frame(b, 1'b1);
    model_push(b, 1'b1);
    repeat (2) @(negedge clk);
    check("t6_irq_before_reset", 32'(irq), 32'd1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (30) @(negedge clk);
        cs = 1'b1; addr = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_wreq_after_reset", 32'(wreq), 32'd1);
        check("t6_irq_after_reset", 32'(irq), 32'd0);
        rst = 1'b0; cs = 1'b0; rd_n = 1'b1;
        model_reset();
        ctrl_read("t6_ctrl_after_reset");
      end
    join
    repeat (3 * CPB) @(negedge clk);
    ctrl_read("t6_no_stale_push");

    // Randomized traffic against the model
    for (int it = 0; it < 8; it++) begin
      for (int n = $urandom_range(0, 5); n > 0; n--) begin
        b    = 8'($urandom);
        stop = ($urandom_range(0, 5) != 0);
        send_frame(b, stop);
        model_push(b, stop);
      end
      for (int n = $urandom_range(1, 6); n > 0; n--) begin
        case ($urandom_range(0, 2))
          0:       data_read("rnd_data_read");
          1:       ctrl_read("rnd_ctrl_read");
          default: ctrl_write($urandom);
        endcase
        repeat (2) @(negedge clk);
        check("rnd_irq_level", 32'(irq), 32'(m_re && (mq.size() != 0)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
